lagarto_plic_gateway: RTL and testbench
=======================================

# lagarto_plic_gateway

- Per-source interrupt gateway for the Lagarto PLIC, sitting directly upstream of the priority/claim core.
- Turns raw asynchronous interrupt lines (source IDs 1..NUM_SOURCES; JTAG0 = ID 1, JTAG1 = ID 2) into one clean pending request per source.
- Each source is held off until the core reports claim and then completion.
- Level- and edge-triggered sources are both supported; edges arriving while a source is busy are counted so none are lost.

## Interface

Parameters:
- NUM_SOURCES, 2: number of interrupt sources; bit k of every vector is source ID k+1.
- MAX_EDGE_COUNT, 3: saturation value of the per-source queued-edge counter; counter width is $clog2(MAX_EDGE_COUNT+1).
- ID_WIDTH, MXLEN: width of claim/complete ID buses (from riscv_privileged_pkg).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rstn_i  in  1  reset; **one clock; reset is asynchronous and active-low**.
- irq_src_i  in  NUM_SOURCES  raw interrupt lines, asynchronous to clk_i.
- edge_sel_i  in  NUM_SOURCES  1 = edge-triggered (rising), 0 = level-triggered (high); quasi-static.
- claim_valid_i  in  1  single-cycle claim strobe from the core.
- claim_id_i  in  ID_WIDTH  ID being claimed.
- complete_valid_i  in  1  single-cycle completion strobe from the core.
- complete_id_i  in  ID_WIDTH  ID being completed.
- pending_o  out  NUM_SOURCES  source has a request awaiting claim.
- in_service_o  out  NUM_SOURCES  source claimed, awaiting completion.

## Operation

Input conditioning:
- Each irq_src_i bit passes through a 2-flop synchronizer (sync1, sync2), plus a third flop (sync3) for edge detection.
- rise = sync2 & ~sync3; lvl = sync2.

Per-source FSM, states IDLE, PENDING, IN_SERVICE:
- IDLE, level mode: lvl=1 -> PENDING.
- IDLE, edge mode: rise=1 or cnt>0 -> PENDING.
  - cnt>0 and no rise: cnt decrements.
  - rise and cnt>0: cnt unchanged (consume one, queue one).
- PENDING: claim_valid_i & claim_id_i==k+1 -> IN_SERVICE.
- IN_SERVICE: complete_valid_i & complete_id_i==k+1 -> IDLE.
- Edge mode, rise while in PENDING or IN_SERVICE: cnt increments, saturating at MAX_EDGE_COUNT. Further edges are dropped.
- Level mode: cnt is forced to 0. Deassertion of the source while PENDING does not withdraw the request.

ID decode and strobe rules:
- claim or complete with ID 0 or ID > NUM_SOURCES: ignored.
- claim to a source not in PENDING: ignored.
- complete to a source not in IN_SERVICE: ignored.
- Claim and complete in the same cycle are evaluated independently against the current state of their target sources. Same ID in the same cycle: only the transition legal from the current state occurs.

Outputs (registered, decoded from state):
- pending_o[k] = (state==PENDING).
- in_service_o[k] = (state==IN_SERVICE).
- Never both high for the same source.

Reset (rstn_i low, asynchronous):
- All sync flops 0, all states IDLE, all cnt 0.
- pending_o = 0, in_service_o = 0.
- Assertion mid-service discards all pending, in-service and queued edges. No request is raised until the synchronizer refills after release.

## Timing

- Source assertion to pending_o:
  - irq_src_i high before edge E0 gives sync1=1 at E0, sync2=1 at E1, PENDING after E2.
  - pending_o is high in the cycle after the third rising edge. Same for edge mode (rise valid between E1 and E2).
- Claim: strobe sampled at edge E; pending_o low and in_service_o high after E (1 cycle).
- Complete: strobe sampled at edge E; in_service_o low after E.
  - Source re-requests (level still high, or cnt>0) pending_o high after E+1. This is a mandatory one-cycle IDLE bubble.
- No combinational path from any input to any output.
- Minimum edge-mode pulse: 2 clk cycles high and 2 low to guarantee detection.

## Test plan

- Reset: hold rstn_i low with irq_src_i=2'b11 -> pending_o=0, in_service_o=0. Release -> pending_o=2'b11 exactly 3 edges after first edge with rstn_i high.
- Level flow, ID 1:
  - Assert irq_src_i[0] -> pending_o[0]=1 after 3 edges.
  - claim_id=1 -> in_service_o[0]=1, pending_o[0]=0 next cycle.
  - Source kept high, complete_id=1 -> one IDLE cycle, then pending_o[0]=1.
  - Source dropped before complete -> stays 0.
- Edge queueing, ID 2, edge_sel=1:
  - 5 rising pulses while IN_SERVICE -> cnt saturates at 3.
  - Each subsequent complete+claim cycle -> pending_o[1] re-asserts exactly 3 times, then stays 0.
- Illegal strobes:
  - claim_id=0, claim_id=3, claim to an IDLE source, complete to a PENDING source -> no state change on any source.
- Simultaneous events:
  - In the same cycle: claim_id=1 (ID 1 PENDING) and complete_id=2 (ID 2 IN_SERVICE) -> both transitions occur in that cycle.
  - claim and complete both to ID 1 while ID 1 is PENDING -> ID 1 ends IN_SERVICE.
- Reset mid-operation: with ID 1 IN_SERVICE and ID 2 cnt=2, pulse rstn_i low asynchronously (between edges) -> outputs 0 immediately; after release with sources low, no pending_o ever asserts.

Source files
------------

// File: rtl/lagarto_plic_gateway.sv
// Per-source interrupt gateway: synchronizes raw IRQ lines and holds each source
// as a single request until the PLIC core has claimed and then completed it.
module lagarto_plic_gateway #(
    parameter int NUM_SOURCES    = 2,
    parameter int MAX_EDGE_COUNT = 3,
    parameter int ID_WIDTH       = 64   // MXLEN of the Lagarto core
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    input  logic [NUM_SOURCES-1:0] edge_sel_i,
    input  logic                   claim_valid_i,
    input  logic [ID_WIDTH-1:0]    claim_id_i,
    input  logic                   complete_valid_i,
    input  logic [ID_WIDTH-1:0]    complete_id_i,
    output logic [NUM_SOURCES-1:0] pending_o,
    output logic [NUM_SOURCES-1:0] in_service_o
);

    localparam int CNT_W = $clog2(MAX_EDGE_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    logic [NUM_SOURCES-1:0] sync1_reg, sync2_reg, sync3_reg;

    // sync3 trails sync2 by one cycle so a rising edge shows up as sync2 & ~sync3
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= irq_src_i;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            state_t            state_reg, state_next;
            logic [CNT_W-1:0]  cnt_reg, cnt_next;
            logic              rise;
            logic              lvl;
            logic              claim_hit;
            logic              complete_hit;
            logic              cnt_full;

            assign lvl          = sync2_reg[gi];
            assign rise         = sync2_reg[gi] & ~sync3_reg[gi];
            assign claim_hit    = claim_valid_i    && (claim_id_i    == ID_WIDTH'(gi + 1));
            assign complete_hit = complete_valid_i && (complete_id_i == ID_WIDTH'(gi + 1));
            assign cnt_full     = (cnt_reg == CNT_W'(MAX_EDGE_COUNT));

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    IDLE: begin
                        if (edge_sel_i[gi]) begin
                            // A fresh edge wins; a queued edge is consumed only when no new one arrives
                            if (rise || cnt_reg != '0)
                                state_next = PENDING;
                            if (!rise && cnt_reg != '0)
                                cnt_next = cnt_reg - CNT_W'(1);
                        end else if (lvl) begin
                            state_next = PENDING;
                        end
                    end
                    PENDING: begin
                        if (claim_hit)
                            state_next = IN_SERVICE;
                        if (rise && !cnt_full)
                            cnt_next = cnt_reg + CNT_W'(1);
                    end
                    IN_SERVICE: begin
                        if (complete_hit)
                            state_next = IDLE;
                        if (rise && !cnt_full)
                            cnt_next = cnt_reg + CNT_W'(1);
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
                if (!edge_sel_i[gi])
                    cnt_next = '0;
            end

            assign pending_o[gi]    = (state_reg == PENDING);
            assign in_service_o[gi] = (state_reg == IN_SERVICE);
        end
    endgenerate

endmodule

// File: tb/tb_lagarto_plic_gateway.sv
// Directed bench for lagarto_plic_gateway: expected output pairs are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_lagarto_plic_gateway;

    localparam int IDW = 64;

    logic           clk = 1'b0;
    logic           rstn;
    logic [1:0]     irq_src;
    logic [1:0]     edge_sel;
    logic           claim_valid;
    logic [IDW-1:0] claim_id;
    logic           complete_valid;
    logic [IDW-1:0] complete_id;
    logic [1:0]     pending;
    logic [1:0]     in_service;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [1:0] pend;
        logic [1:0] ins;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lagarto_plic_gateway #(
        .NUM_SOURCES   (2),
        .MAX_EDGE_COUNT(3),
        .ID_WIDTH      (IDW)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .irq_src_i       (irq_src),
        .edge_sel_i      (edge_sel),
        .claim_valid_i   (claim_valid),
        .claim_id_i      (claim_id),
        .complete_valid_i(complete_valid),
        .complete_id_i   (complete_id),
        .pending_o       (pending),
        .in_service_o    (in_service)
    );

    task automatic push_exp(input string tag, input logic [1:0] p, input logic [1:0] i);
        exp_t e;
        e.tag  = tag;
        e.pend = p;
        e.ins  = i;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        assert ({pending, in_service} === {e.pend, e.ins})
        else begin
            n_err++;
            $error("FAIL %s: observed pend=%b ins=%b, expected pend=%b ins=%b",
                   e.tag, pending, in_service, e.pend, e.ins);
        end
    endtask

    // one clock: queue expectation, let the edge pass, sample 1ns later
    task automatic cyc(input string tag, input logic [1:0] p, input logic [1:0] i);
        push_exp(tag, p, i);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic claim(input int id, input string tag, input logic [1:0] p, input logic [1:0] i);
        claim_valid = 1'b1;
        claim_id    = IDW'(id);
        cyc(tag, p, i);
        claim_valid = 1'b0;
        claim_id    = '0;
    endtask

    task automatic complete(input int id, input string tag, input logic [1:0] p, input logic [1:0] i);
        complete_valid = 1'b1;
        complete_id    = IDW'(id);
        cyc(tag, p, i);
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic both(input int cid, input int pid, input string tag,
                        input logic [1:0] p, input logic [1:0] i);
        claim_valid    = 1'b1;
        claim_id       = IDW'(cid);
        complete_valid = 1'b1;
        complete_id    = IDW'(pid);
        cyc(tag, p, i);
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    // 2 cycles high, 2 low on source ID 2
    task automatic pulse2(input string tag, input logic [1:0] p_early,
                          input logic [1:0] p_late, input logic [1:0] i);
        irq_src[1] = 1'b1;
        cyc(tag, p_early, i);
        cyc(tag, p_early, i);
        irq_src[1] = 1'b0;
        cyc(tag, p_late, i);
        cyc(tag, p_late, i);
    endtask

    initial begin
        rstn           = 1'b0;
        irq_src        = 2'b11;
        edge_sel       = 2'b00;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;

        repeat (3) cyc("rst_hold", 2'b00, 2'b00);
        rstn = 1'b1;
        cyc("rst_rel_e0", 2'b00, 2'b00);
        cyc("rst_rel_e1", 2'b00, 2'b00);
        cyc("rst_rel_e2", 2'b11, 2'b00);

        // level flow on ID 1
        claim(1, "lvl_claim1", 2'b10, 2'b01);
        complete(1, "lvl_cpl1_bubble", 2'b10, 2'b00);
        cyc("lvl_rerequest", 2'b11, 2'b00);
        claim(1, "lvl_claim1_b", 2'b10, 2'b01);
        irq_src[0] = 1'b0;
        repeat (2) cyc("lvl_drop_wait", 2'b10, 2'b01);
        complete(1, "lvl_cpl1_dropped", 2'b10, 2'b00);
        repeat (2) cyc("lvl_stays_idle", 2'b10, 2'b00);

        // retire ID 2 and switch it to edge mode
        claim(2, "lvl_claim2", 2'b00, 2'b10);
        irq_src[1] = 1'b0;
        repeat (2) cyc("lvl2_drop_wait", 2'b00, 2'b10);
        complete(2, "lvl_cpl2", 2'b00, 2'b00);
        edge_sel = 2'b10;

        // illegal strobes against idle sources
        claim(0, "claim_id0", 2'b00, 2'b00);
        claim(3, "claim_id3", 2'b00, 2'b00);
        claim(1, "claim_idle", 2'b00, 2'b00);

        // edge mode: single pulse, then saturating queue
        pulse2("edge_first", 2'b00, 2'b10, 2'b00);
        complete(2, "cpl_pending", 2'b10, 2'b00);
        claim(0, "claim0_pending", 2'b10, 2'b00);
        claim(2, "edge_claim2", 2'b00, 2'b10);
        repeat (5) pulse2("edge_queue", 2'b00, 2'b00, 2'b10);
        repeat (3) begin
            complete(2, "edge_cpl_bubble", 2'b00, 2'b00);
            cyc("edge_requeue", 2'b10, 2'b00);
            claim(2, "edge_reclaim", 2'b00, 2'b10);
        end
        complete(2, "edge_cpl_last", 2'b00, 2'b00);
        repeat (3) cyc("edge_drained", 2'b00, 2'b00);

        // simultaneous claim of ID 1 and complete of ID 2
        pulse2("sim_setup2", 2'b00, 2'b10, 2'b00);
        claim(2, "sim_claim2", 2'b00, 2'b10);
        irq_src[0] = 1'b1;
        cyc("sim_src1_e0", 2'b00, 2'b10);
        cyc("sim_src1_e1", 2'b00, 2'b10);
        cyc("sim_src1_e2", 2'b01, 2'b10);
        both(1, 2, "sim_claim1_cpl2", 2'b00, 2'b01);
        cyc("sim_after", 2'b00, 2'b01);

        // claim and complete to ID 1 while pending
        complete(1, "same_setup_cpl", 2'b00, 2'b00);
        cyc("same_setup_req", 2'b01, 2'b00);
        both(1, 1, "same_id_both", 2'b00, 2'b01);

        // asynchronous reset with ID 1 in service and two edges queued on ID 2
        pulse2("rst_setup2", 2'b00, 2'b10, 2'b01);
        claim(2, "rst_claim2", 2'b00, 2'b11);
        repeat (2) pulse2("rst_queue", 2'b00, 2'b00, 2'b11);
        irq_src = 2'b00;
        #3;
        rstn = 1'b0;
        #1;
        push_exp("async_rst_now", 2'b00, 2'b00);
        check_out();
        @(posedge clk);
        #1;
        push_exp("async_rst_hold", 2'b00, 2'b00);
        check_out();
        rstn = 1'b1;
        repeat (6) cyc("post_rst_quiet", 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
